// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter sharing one 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) among
// NUM_REQ requesters; a seed load reseeds the generator and runs a warm-up.
module lfsr_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter logic [7:0]  SEED_DEFAULT  = 8'h8A,
    parameter int unsigned WARMUP_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seed_load,
    input  logic [7:0]         seed,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [7:0]         data,
    output logic               busy
);
    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        RUN,
        WARMUP
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [7:0]         data_q, data_d;
    logic               busy_q, busy_d;

    logic [7:0]         lfsr_step;
    logic               win_found;
    logic [PW-1:0]      win_idx;
    int unsigned        idx;

    assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Scan from ptr+1 upward with wrap; the first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(ptr_q) + k) % NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        data_d  = data_q;
        busy_d  = busy_q;

        if (seed_load) begin
            lfsr_d = (seed == 8'h00) ? SEED_DEFAULT : seed;
            if (WARMUP_CYCLES > 0) begin
                state_d = WARMUP;
                cnt_d   = 8'(WARMUP_CYCLES);
                busy_d  = 1'b1;
            end else begin
                state_d = RUN;
                busy_d  = 1'b0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (win_found) begin
                        gnt_d[win_idx] = 1'b1;
                        data_d         = lfsr_q;
                        lfsr_d         = lfsr_step;
                        ptr_d          = win_idx;
                    end
                end
                WARMUP: begin
                    lfsr_d = lfsr_step;
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = RUN;
                        busy_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            lfsr_q  <= SEED_DEFAULT;
            cnt_q   <= '0;
            ptr_q   <= PW'(NUM_REQ - 1);
            gnt_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign data = data_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Self-checking bench for lfsr_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_lfsr_arbiter;
    localparam int NREQ = 4;
    localparam int WARM = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            seed_load = 1'b0;
    logic [7:0]      seed = 8'h00;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [7:0]      data;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_lfsr, m_ptr, m_warm, m_gnt, m_data, m_busy;

    lfsr_arbiter #(
        .NUM_REQ      (NREQ),
        .SEED_DEFAULT (8'h8A),
        .WARMUP_CYCLES(WARM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .seed_load(seed_load),
        .seed     (seed),
        .req      (req),
        .gnt      (gnt),
        .data     (data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_val(input int x);
        bit [7:0] v;
        v = 8'(x);
        return ((x << 1) & 8'hFE) | int'(^(v & 8'hB8));
    endfunction

    task automatic model_reset();
        m_lfsr = 8'h8A; m_ptr = NREQ - 1; m_warm = 0;
        m_gnt = 0; m_data = 0; m_busy = 0;
    endtask

    task automatic model_edge(input bit sl, input int sd, input int rq);
        m_gnt = 0;
        if (sl) begin
            m_lfsr = (sd == 0) ? 8'h8A : sd;
            m_warm = WARM;
            m_busy = (WARM > 0);
        end else if (m_warm > 0) begin
            m_lfsr = next_val(m_lfsr);
            m_warm--;
            m_busy = (m_warm > 0);
        end else if (rq != 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (m_gnt == 0 && rq[i]) begin
                    m_gnt  = 1 << i;
                    m_data = m_lfsr;
                    m_lfsr = next_val(m_lfsr);
                    m_ptr  = i;
                end
            end
        end
    endtask

    task automatic cyc(input bit sl, input bit [7:0] sd, input bit [NREQ-1:0] rq);
        seed_load = sl; seed = sd; req = rq;
        @(posedge clk);
        model_edge(sl, sd, rq);
        #1;
        chk("gnt", gnt, m_gnt);
        chk("data", data, m_data);
        chk("busy", busy, m_busy);
    endtask

    // Asserts reset mid-cycle and confirms outputs clear without a clock edge.
    task automatic do_reset();
        seed_load = 1'b0; req = '0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit [7:0] exp_seq [9] = '{8'h8A, 8'h14, 8'h29, 8'h52, 8'hA5, 8'h4A, 8'h95, 8'h2A, 8'h54};
        model_reset();
        #3;
        chk("rst_gnt", gnt, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: single byte twice
        cyc(0, 0, 4'b0001);
        chk("t1_data0", data, exp_seq[0]);
        cyc(0, 0, 4'b0000);
        cyc(0, 0, 4'b0001);
        chk("t1_data1", data, exp_seq[1]);
        cyc(0, 0, 4'b0000);

        // 2: all requesting, round-robin order from fresh reset
        do_reset();
        for (int n = 0; n < 5; n++) begin
            cyc(0, 0, 4'b1111);
            chk("t2_gnt", gnt, 1 << (n % 4));
            chk("t2_data", data, exp_seq[n]);
        end

        // 3: two requesters alternate
        do_reset();
        for (int n = 0; n < 9; n++) begin
            cyc(0, 0, 4'b0101);
            chk("t3_gnt", gnt, (n % 2 == 0) ? 4'b0001 : 4'b0100);
            chk("t3_data", data, exp_seq[n]);
        end

        // 4: zero seed substitutes default, warm-up then grant
        cyc(1, 8'h00, 4'b0010);
        for (int n = 0; n < WARM - 1; n++) cyc(0, 0, 4'b0010);
        chk("t4_busy_last", busy, 1);
        cyc(0, 0, 4'b0010);
        chk("t4_busy_fall", busy, 0);
        chk("t4_gnt_none", gnt, 0);
        cyc(0, 0, 4'b0010);
        chk("t4_gnt", gnt, 4'b0010);
        chk("t4_data", data, 8'h54);
        cyc(0, 0, 4'b0000);

        // 5: seed_load beats req; reload mid warm-up restarts count
        cyc(1, 8'h29, 4'b1111);
        chk("t5_nogrant", gnt, 0);
        for (int n = 0; n < 3; n++) cyc(0, 0, 4'b1111);
        cyc(1, 8'h29, 4'b1111);
        for (int n = 0; n < WARM - 1; n++) cyc(0, 0, 4'b1111);
        chk("t5_busy_ext", busy, 1);
        cyc(0, 0, 4'b1111);
        chk("t5_busy_fall", busy, 0);
        cyc(0, 0, 4'b1111);

        // 6: reset during back-to-back grants
        for (int n = 0; n < 3; n++) cyc(0, 0, 4'b1111);
        do_reset();
        cyc(0, 0, 4'b0110);
        chk("t6_gnt", gnt, 4'b0010);
        chk("t6_data", data, 8'h8A);

        // reset during warm-up clears busy asynchronously
        cyc(1, 8'h33, 4'b0000);
        cyc(0, 0, 4'b0000);
        do_reset();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit sl;
            bit [7:0] sd;
            sl = ($urandom_range(0, 24) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cyc(sl, sd, NREQ'($urandom));
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
